// File: rtl/p7_defs.sv
// Shared p7 pipeline definitions: PC-update source codes, next-PC sequencer states
// and the legal text-segment window.
package p7_defs;

  localparam logic [1:0] SRC_SEQ  = 2'd0;
  localparam logic [1:0] SRC_BR   = 2'd1;
  localparam logic [1:0] SRC_ERET = 2'd2;
  localparam logic [1:0] SRC_EXC  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_e;

  localparam logic [31:0] TEXT_LO = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI = 32'h0000_6FFC;

endpackage

// File: rtl/pc_sequencer.sv
// Next-PC controller for p7: arbitrates exception/eret/branch/sequential PC sources,
// buffers branches that land in a stall, and sequences the post-redirect flush window.
// Optional fetch address-error flag enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer
  import p7_defs::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY    = 32'h0000_4180,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cur_pc,
  input  logic        stall,
  input  logic        m_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        pc_we,
  output logic [31:0] next_pc,
  output logic        flush_all,
  output logic [1:0]  redirect_src,
`ifdef PC_ALIGN_CHECK_EN
  output logic        fetch_adel,
`endif
  output logic        pend_valid
);

  localparam logic [2:0] FLUSH_INIT = FLUSH_CYCLES[2:0];

  seq_state_e  state, state_nxt;
  logic [31:0] pend_target, pend_target_nxt;
  logic        pend_valid_nxt;
  logic [2:0]  flush_cnt, flush_cnt_nxt;
  logic        hold;
  logic [31:0] seq_pc;

  assign hold   = stall | m_stall;
  assign seq_pc = cur_pc + 32'd4;

  always_comb begin
    pc_we           = 1'b0;
    next_pc         = seq_pc;
    redirect_src    = SRC_SEQ;
    flush_all       = 1'b0;
    state_nxt       = state;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;
    flush_cnt_nxt   = flush_cnt;

    // CP0 redirects override everything, including stalls
    if (exc_req || eret_req) begin
      pc_we          = 1'b1;
      next_pc        = exc_req ? EXC_ENTRY : epc;
      redirect_src   = exc_req ? SRC_EXC : SRC_ERET;
      flush_all      = 1'b1;
      pend_valid_nxt = 1'b0;
      flush_cnt_nxt  = FLUSH_INIT;
      state_nxt      = ST_FLUSH;
    end else begin
      case (state)
        ST_RUN: begin
          if (!hold) begin
            pc_we = 1'b1;
            if (pend_valid) begin
              next_pc        = pend_target;
              redirect_src   = SRC_BR;
              pend_valid_nxt = 1'b0;
            end else if (br_taken) begin
              next_pc      = br_target;
              redirect_src = SRC_BR;
            end
          end else if (br_taken && !pend_valid) begin
            pend_target_nxt = br_target;
            pend_valid_nxt  = 1'b1;
            state_nxt       = ST_HOLD;
          end
        end
        ST_HOLD: begin
          next_pc      = pend_target;
          redirect_src = SRC_BR;
          if (!hold) begin
            pc_we          = 1'b1;
            pend_valid_nxt = 1'b0;
            state_nxt      = ST_RUN;
          end
        end
        ST_FLUSH: begin
          pc_we = !hold;
          // counter runs down regardless of stalls; a zero count is treated as expired
          if (flush_cnt <= 3'd1) begin
            flush_cnt_nxt = 3'd0;
            state_nxt     = ST_RUN;
          end else begin
            flush_cnt_nxt = flush_cnt - 3'd1;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end

    if (!reset_n) begin
      pc_we        = 1'b0;
      next_pc      = RESET_PC;
      redirect_src = SRC_SEQ;
      flush_all    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      pend_valid  <= 1'b0;
      pend_target <= 32'd0;
      flush_cnt   <= 3'd0;
    end else begin
      state       <= state_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
      flush_cnt   <= flush_cnt_nxt;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic bad_addr;
  assign bad_addr = (next_pc[1:0] != 2'b00) || (next_pc < TEXT_LO) || (next_pc > TEXT_HI);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     fetch_adel <= 1'b0;
    else if (exc_req) fetch_adel <= 1'b0;
    else if (pc_we)   fetch_adel <= bad_addr;
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a behavioural next-PC model.
// Define PC_ALIGN_CHECK_EN to also exercise the fetch address-error flag.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cur_pc;
  logic        stall, m_stall, br_taken, exc_req, eret_req;
  logic [31:0] br_target, epc;
  logic        pc_we, flush_all, pend_valid;
  logic [31:0] next_pc;
  logic [1:0]  redirect_src;
`ifdef PC_ALIGN_CHECK_EN
  logic        fetch_adel;
`endif

  int errors = 0;
  int checks = 0;

  // behavioural model: a pending branch implies the sequencer is waiting out a stall
  logic        m_pend_v;
  logic [31:0] m_pend_t;
  int          m_flush_left;

  logic        obs_we, obs_fl, obs_pv;
  logic [31:0] obs_pc;
  logic [1:0]  obs_src;

  pc_sequencer dut (
    .clk(clk), .reset_n(reset_n), .cur_pc(cur_pc), .stall(stall), .m_stall(m_stall),
    .br_taken(br_taken), .br_target(br_target), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .pc_we(pc_we), .next_pc(next_pc), .flush_all(flush_all),
    .redirect_src(redirect_src),
`ifdef PC_ALIGN_CHECK_EN
    .fetch_adel(fetch_adel),
`endif
    .pend_valid(pend_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic mst, input logic br, input logic [31:0] tgt,
                       input logic exc, input logic eret, input logic [31:0] ep);
    stall = st; m_stall = mst; br_taken = br; br_target = tgt;
    exc_req = exc; eret_req = eret; epc = ep;
  endtask

  task automatic model_reset();
    m_pend_v = 1'b0; m_pend_t = 32'd0; m_flush_left = 0;
  endtask

  // one clock: check outputs mid-cycle against the model, then advance model and PC register
  task automatic step();
    logic hold, e_we, e_fl, n_pv;
    logic [31:0] e_pc, n_pt;
    logic [1:0] e_src;
    int n_fl;
    @(negedge clk);
    hold = stall | m_stall;
    e_we = 1'b0; e_fl = 1'b0; e_pc = cur_pc + 32'd4; e_src = 2'd0;
    n_pv = m_pend_v; n_pt = m_pend_t; n_fl = m_flush_left;
    if (exc_req || eret_req) begin
      e_we = 1'b1; e_fl = 1'b1;
      e_pc = exc_req ? 32'h0000_4180 : epc;
      e_src = exc_req ? 2'd3 : 2'd2;
      n_pv = 1'b0; n_fl = 1;
    end else if (m_flush_left > 0) begin
      e_we = !hold; n_fl = m_flush_left - 1;
    end else if (m_pend_v) begin
      if (!hold) begin
        e_we = 1'b1; e_pc = m_pend_t; e_src = 2'd1; n_pv = 1'b0;
      end
    end else if (!hold) begin
      e_we = 1'b1;
      if (br_taken) begin e_pc = br_target; e_src = 2'd1; end
    end else if (br_taken) begin
      n_pv = 1'b1; n_pt = br_target;
    end
    obs_we = pc_we; obs_pc = next_pc; obs_src = redirect_src; obs_fl = flush_all; obs_pv = pend_valid;
    check("pc_we", {31'd0, pc_we}, {31'd0, e_we});
    check("flush_all", {31'd0, flush_all}, {31'd0, e_fl});
    check("pend_valid", {31'd0, pend_valid}, {31'd0, m_pend_v});
    if (e_we) begin
      check("next_pc", next_pc, e_pc);
      check("redirect_src", {30'd0, redirect_src}, {30'd0, e_src});
    end
    @(posedge clk);
    #1;
    m_pend_v = n_pv; m_pend_t = n_pt; m_flush_left = n_fl;
    if (e_we) cur_pc = e_pc;
  endtask

  function automatic logic [31:0] rand_text();
    return {$urandom_range(32'h3000 >> 2, 32'h6FFC >> 2)} << 2;
  endfunction

  initial begin
    reset_n = 1'b0; cur_pc = 32'h3000;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 25), rand_text(),
            ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 4), rand_text());
      step();
    end

    // async reset mid-operation discards a pending branch
    drive(1, 0, 1, 32'h3500, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_pc_we", {31'd0, pc_we}, 32'd0);
    check("rst_next_pc", next_pc, 32'h3000);
    check("rst_pend", {31'd0, pend_valid}, 32'd0);
    check("rst_flush", {31'd0, flush_all}, 32'd0);
    check("rst_src", {30'd0, redirect_src}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1; cur_pc = 32'h3000;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check("t1_pc", obs_pc, 32'h3004);
    check("t1_src", {30'd0, obs_src}, 32'd0);

    // branch during stall is buffered and applied on release
    cur_pc = 32'h3010;
    drive(1, 0, 1, 32'h3040, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    check("t2_pend", {31'd0, obs_pv}, 32'd1);
    check("t2_we", {31'd0, obs_we}, 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check("t2_pc", obs_pc, 32'h3040);
    check("t2_src", {30'd0, obs_src}, 32'd1);
    step();
    check("t2_pend_clr", {31'd0, obs_pv}, 32'd0);

    // exception under mult/div stall, branch in flush window ignored
    drive(0, 1, 0, 0, 1, 0, 0);
    step();
    check("t3_pc", obs_pc, 32'h4180);
    check("t3_src", {30'd0, obs_src}, 32'd3);
    check("t3_flush", {31'd0, obs_fl}, 32'd1);
    drive(0, 0, 1, 32'h3300, 0, 0, 0);
    step();
    check("t3_ign_pc", obs_pc, 32'h4184);
    check("t3_flush_end", {31'd0, obs_fl}, 32'd0);

    // exception beats eret; eret alone returns to epc
    drive(0, 0, 0, 0, 1, 1, 32'h3020);
    step();
    check("t4_exc_pc", obs_pc, 32'h4180);
    drive(0, 0, 0, 0, 0, 1, 32'h3020);
    step();
    check("t4_eret_pc", obs_pc, 32'h3020);
    check("t4_eret_src", {30'd0, obs_src}, 32'd2);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();

    // pending branch wins over a new branch on release
    drive(1, 0, 1, 32'h3100, 0, 0, 0);
    step();
    drive(0, 0, 1, 32'h3200, 0, 0, 0);
    step();
    check("t5_pc", obs_pc, 32'h3100);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check("t5_drop", obs_pc, 32'h3104);

    // sequential increment wraps at 2^32
    cur_pc = 32'hFFFF_FFFC;
    step();
    check("wrap_pc", obs_pc, 32'h0);

`ifdef PC_ALIGN_CHECK_EN
    drive(0, 0, 1, 32'h3042, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    check("t6_adel_set", {31'd0, fetch_adel}, 32'd1);
    drive(0, 0, 0, 0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    check("t6_adel_clr", {31'd0, fetch_adel}, 32'd0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
